// File: rtl/otn_pkg.sv
// Shared OTN framing definitions: frame alignment word, CRC-8 polynomial and
// bit-serial update, receiver state encoding.
package otn_pkg;

    localparam logic [15:0] FAS_WORD_DEFAULT = 16'hF628;
    localparam logic [7:0]  CRC8_POLY        = 8'h07;

    typedef enum logic [1:0] {
        HUNT  = 2'd0,
        PYLD  = 2'd1,
        CRCB  = 2'd2,
        DRAIN = 2'd3
    } rx_state_e;

    // One MSB-first bit step of CRC-8 (x^8+x^2+x+1), no reflection.
    function automatic logic [7:0] crc8_next(input logic [7:0] byte_crc, input logic bit_in);
        logic fb;
        fb = byte_crc[7] ^ bit_in;
        return {byte_crc[6:0], 1'b0} ^ (fb ? CRC8_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/crc8_serial.sv
// Bit-serial CRC-8 register; clear has priority over enable.
module crc8_serial
    import otn_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_clr,
    input  logic       i_en,
    input  logic       i_bit,
    output logic [7:0] o_crc
);

    logic [7:0] r_crc;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_crc <= '0;
        end else if (i_en) begin
            r_crc <= crc8_next(r_crc, i_bit);
        end
    end

    assign o_crc = r_crc;

endmodule

// File: rtl/otn_frame_receiver.sv
// OTN serial frame receiver: FAS hunt, payload capture with CRC-8 check, AXIS drain and ACK.
// Optional RX_STATS_EN adds saturating good/bad/drop frame counters.
module otn_frame_receiver
    import otn_pkg::*;
#(
    parameter int unsigned PYLD_BYTES = 16,
    parameter logic [15:0] FAS_WORD   = FAS_WORD_DEFAULT,
    parameter int unsigned ACK_CYCLES = 8
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_otn_rx_data,
    input  logic        i_bit_en,
    output logic        o_otn_tx_ack,
    output logic [7:0]  o_pyld_data,
    output logic        o_pyld_data_valid,
    input  logic        i_pyld_data_ready,
    output logic        o_in_frame,
    output logic        o_crc_err,
    output logic        o_drop
`ifdef RX_STATS_EN
    ,
    output logic [15:0] o_good_cnt,
    output logic [15:0] o_bad_cnt,
    output logic [15:0] o_drop_cnt
`endif
);

    localparam int unsigned BYTE_W = $clog2(PYLD_BYTES + 1);
    localparam int unsigned IDX_W  = (PYLD_BYTES > 1) ? $clog2(PYLD_BYTES) : 1;
    localparam int unsigned ACK_W  = $clog2(ACK_CYCLES + 1);

    localparam logic [BYTE_W-1:0] LAST_BYTE = BYTE_W'(PYLD_BYTES - 1);
    localparam logic [BYTE_W-1:0] NUM_BYTES = BYTE_W'(PYLD_BYTES);
    localparam logic [ACK_W-1:0]  ACK_LOAD  = ACK_W'(ACK_CYCLES);

    rx_state_e         r_state;
    rx_state_e         w_state_nxt;
    logic [15:0]       r_shift;
    logic [15:0]       w_shift_nxt;
    logic [2:0]        r_bit_cnt;
    logic [BYTE_W-1:0] r_byte_cnt;
    logic [BYTE_W-1:0] r_rd_idx;
    logic [7:0]        r_buf [PYLD_BYTES];
    logic [7:0]        w_crc;
    logic [ACK_W-1:0]  r_ack_cnt;

    logic        r_ack;
    logic [7:0]  r_pyld_data;
    logic        r_pyld_valid;
    logic        r_in_frame;
    logic        r_crc_err;
    logic        r_drop;

    logic w_fas_hit;
    logic w_byte_done;
    logic w_drain_last;
    logic w_load;
    logic w_start;
    logic w_crc_ok;
    logic w_crc_bad;
    logic w_drop;
    logic w_crc_en;

    assign w_shift_nxt  = {r_shift[14:0], i_otn_rx_data};
    assign w_fas_hit    = i_bit_en && (w_shift_nxt == FAS_WORD);
    assign w_byte_done  = i_bit_en && (r_bit_cnt == 3'd7);
    assign w_drain_last = r_pyld_valid && i_pyld_data_ready && (r_rd_idx == NUM_BYTES);
    assign w_load       = (r_state == DRAIN) && (!r_pyld_valid || i_pyld_data_ready)
                          && (r_rd_idx < NUM_BYTES);
    assign w_crc_en     = (r_state == PYLD) && i_bit_en;

    crc8_serial u_crc (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_clr (w_start),
        .i_en  (w_crc_en),
        .i_bit (i_otn_rx_data),
        .o_crc (w_crc)
    );

    // Next state; a FAS landing on the final drain handshake is taken as a fresh hunt hit.
    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_crc_ok    = 1'b0;
        w_crc_bad   = 1'b0;
        w_drop      = 1'b0;
        case (r_state)
            HUNT: begin
                if (w_fas_hit) begin
                    w_state_nxt = PYLD;
                    w_start     = 1'b1;
                end
            end
            PYLD: begin
                if (w_byte_done && (r_byte_cnt == LAST_BYTE)) begin
                    w_state_nxt = CRCB;
                end
            end
            CRCB: begin
                if (w_byte_done) begin
                    if (w_shift_nxt[7:0] == w_crc) begin
                        w_state_nxt = DRAIN;
                        w_crc_ok    = 1'b1;
                    end else begin
                        w_state_nxt = HUNT;
                        w_crc_bad   = 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (w_drain_last) begin
                    if (w_fas_hit) begin
                        w_state_nxt = PYLD;
                        w_start     = 1'b1;
                    end else begin
                        w_state_nxt = HUNT;
                    end
                end else if (w_fas_hit) begin
                    w_drop = 1'b1;
                end
            end
            default: w_state_nxt = HUNT;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= HUNT;
            r_shift      <= '0;
            r_bit_cnt    <= '0;
            r_byte_cnt   <= '0;
            r_rd_idx     <= '0;
            r_ack_cnt    <= '0;
            r_ack        <= 1'b0;
            r_pyld_data  <= '0;
            r_pyld_valid <= 1'b0;
            r_in_frame   <= 1'b0;
            r_crc_err    <= 1'b0;
            r_drop       <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (i_bit_en) begin
                r_shift <= w_shift_nxt;
            end

            if (w_start) begin
                r_bit_cnt  <= '0;
                r_byte_cnt <= '0;
            end else if (((r_state == PYLD) || (r_state == CRCB)) && i_bit_en) begin
                r_bit_cnt <= r_bit_cnt + 3'd1;
                if ((r_state == PYLD) && w_byte_done) begin
                    r_byte_cnt <= r_byte_cnt + BYTE_W'(1);
                end
            end

            // AXIS read side: prefetch next byte whenever the output slot is free.
            if (w_crc_ok) begin
                r_rd_idx <= '0;
            end else if (w_load) begin
                r_rd_idx <= r_rd_idx + BYTE_W'(1);
            end
            if (w_load) begin
                r_pyld_data  <= r_buf[r_rd_idx[IDX_W-1:0]];
                r_pyld_valid <= 1'b1;
            end else if (r_pyld_valid && i_pyld_data_ready) begin
                r_pyld_valid <= 1'b0;
            end

            // ACK holds for ACK_CYCLES; a new good frame reloads it.
            if (w_crc_ok) begin
                r_ack_cnt <= ACK_LOAD;
                r_ack     <= 1'b1;
            end else begin
                r_ack <= (r_ack_cnt > ACK_W'(1));
                if (r_ack_cnt != '0) begin
                    r_ack_cnt <= r_ack_cnt - ACK_W'(1);
                end
            end

            r_in_frame <= (w_state_nxt == PYLD) || (w_state_nxt == CRCB);
            r_crc_err  <= w_crc_bad;
            r_drop     <= w_drop;
        end
    end

    // Payload buffer; contents are don't-care after reset.
    always_ff @(posedge i_clk) begin
        if ((r_state == PYLD) && w_byte_done) begin
            r_buf[r_byte_cnt[IDX_W-1:0]] <= w_shift_nxt[7:0];
        end
    end

`ifdef RX_STATS_EN
    logic [15:0] r_good_cnt;
    logic [15:0] r_bad_cnt;
    logic [15:0] r_drop_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_good_cnt <= '0;
            r_bad_cnt  <= '0;
            r_drop_cnt <= '0;
        end else begin
            if (w_crc_ok && (r_good_cnt != 16'hFFFF)) begin
                r_good_cnt <= r_good_cnt + 16'd1;
            end
            if (w_crc_bad && (r_bad_cnt != 16'hFFFF)) begin
                r_bad_cnt <= r_bad_cnt + 16'd1;
            end
            if (w_drop && (r_drop_cnt != 16'hFFFF)) begin
                r_drop_cnt <= r_drop_cnt + 16'd1;
            end
        end
    end

    assign o_good_cnt = r_good_cnt;
    assign o_bad_cnt  = r_bad_cnt;
    assign o_drop_cnt = r_drop_cnt;
`endif

    assign o_otn_tx_ack      = r_ack;
    assign o_pyld_data       = r_pyld_data;
    assign o_pyld_data_valid = r_pyld_valid;
    assign o_in_frame        = r_in_frame;
    assign o_crc_err         = r_crc_err;
    assign o_drop            = r_drop;

endmodule

// File: tb/tb_otn_frame_receiver.sv
// Scoreboard bench for otn_frame_receiver: serial frames in, AXIS bytes checked against a queue.
module tb_otn_frame_receiver;

    logic        clk;
    logic        rst;
    logic        rx_data;
    logic        bit_en;
    logic        ack;
    logic [7:0]  pdata;
    logic        vld;
    logic        rdy;
    logic        in_frame;
    logic        crc_err;
    logic        drop;
`ifdef RX_STATS_EN
    logic [15:0] good_cnt;
    logic [15:0] bad_cnt;
    logic [15:0] drop_cnt;
`endif

    int         n_total     = 0;
    int         n_bad       = 0;
    logic [7:0] sb_q[$];
    int         ack_run     = 0;
    int         ack_pulses  = 0;
    int         err_pulses  = 0;
    int         drop_pulses = 0;
    int         rdy_mode    = 0;
    logic       prev_stall  = 1'b0;
    logic [7:0] prev_data   = 8'h00;

    otn_frame_receiver #(
        .PYLD_BYTES (16),
        .FAS_WORD   (16'hF628),
        .ACK_CYCLES (8)
    ) dut (
        .i_clk             (clk),
        .i_rst             (rst),
        .i_otn_rx_data     (rx_data),
        .i_bit_en          (bit_en),
        .o_otn_tx_ack      (ack),
        .o_pyld_data       (pdata),
        .o_pyld_data_valid (vld),
        .i_pyld_data_ready (rdy),
        .o_in_frame        (in_frame),
        .o_crc_err         (crc_err),
        .o_drop            (drop)
`ifdef RX_STATS_EN
        ,
        .o_good_cnt        (good_cnt),
        .o_bad_cnt         (bad_cnt),
        .o_drop_cnt        (drop_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        repeat (50000) @(posedge clk);
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_total++;
        if (obs !== want) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Ready pattern: 0 = always ready, 1 = toggle every cycle, other = held low.
    initial begin
        rdy = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       rdy = 1'b1;
                1:       rdy = ~rdy;
                default: rdy = 1'b0;
            endcase
        end
    end

    // Output monitor: scoreboard pop, stall stability, ACK width and pulse counting.
    initial begin
        logic [7:0] want;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 1'b0;
                ack_run    = 0;
            end else begin
                if (prev_stall) begin
                    chk_eq("hold_valid", 32'(vld), 32'd1);
                    chk_eq("hold_data", 32'(pdata), 32'(prev_data));
                end
                if (vld && rdy) begin
                    if (sb_q.size() == 0) begin
                        chk_eq("unexpected_byte", 32'(vld), 32'd0);
                    end else begin
                        want = sb_q.pop_front();
                        chk_eq("pyld_byte", 32'(pdata), 32'(want));
                    end
                end
                prev_stall = vld && !rdy;
                prev_data  = pdata;
                if (ack) begin
                    ack_run++;
                end else if (ack_run != 0) begin
                    chk_eq("ack_len", 32'(ack_run), 32'd8);
                    ack_pulses++;
                    ack_run = 0;
                end
                if (crc_err) err_pulses++;
                if (drop)    drop_pulses++;
            end
        end
    end

    function automatic logic [7:0] crc8_ref(input logic [7:0] pl [16]);
        logic [7:0] c;
        c = 8'h00;
        for (int k = 0; k < 16; k++) begin
            c = c ^ pl[k];
            for (int j = 0; j < 8; j++) begin
                c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
            end
        end
        return c;
    endfunction

    task automatic send_bit(input logic b, input bit sparse);
        if (sparse) begin
            bit_en = 1'b0;
            repeat (3) tick();
        end
        rx_data = b;
        bit_en  = 1'b1;
        tick();
        bit_en  = 1'b0;
        rx_data = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] v, input bit sparse);
        for (int i = 7; i >= 0; i--) send_bit(v[i], sparse);
    endtask

    // FAS, nbytes of payload (optional single bit flip), then CRC if the payload is complete.
    task automatic send_frame(input logic [7:0] pl [16], input int flip, input int nbytes,
                              input bit push, input bit sparse);
        logic [7:0] crc;
        logic [7:0] b;
        crc = crc8_ref(pl);
        if (push) begin
            for (int k = 0; k < 16; k++) sb_q.push_back(pl[k]);
        end
        send_byte(8'hF6, sparse);
        send_byte(8'h28, sparse);
        for (int k = 0; k < nbytes; k++) begin
            b = pl[k];
            if ((flip >= 0) && ((flip / 8) == k)) b = b ^ (8'h80 >> (flip % 8));
            send_byte(b, sparse);
        end
        if (nbytes == 16) send_byte(crc, sparse);
    endtask

    task automatic wait_drain();
        for (int i = 0; (i < 3000) && (sb_q.size() != 0); i++) tick();
        chk_eq("drain_done", 32'(sb_q.size()), 32'd0);
        sb_q.delete();
        repeat (12) tick();
        chk_eq("idle_valid", 32'(vld), 32'd0);
    endtask

    initial begin
        logic [7:0] pl_inc [16];
        logic [7:0] pl_rnd [16];
        logic [7:0] pl_alt [16];
        logic [7:0] pl_zero [16];
        int a0;
        int e0;
        int d0;

        for (int i = 0; i < 16; i++) begin
            pl_inc[i]  = 8'(i);
            pl_rnd[i]  = 8'($urandom_range(0, 255));
            pl_alt[i]  = 8'(8'hA5 ^ (i * 17));
            pl_zero[i] = 8'h00;
        end

        rst     = 1'b1;
        rx_data = 1'b0;
        bit_en  = 1'b0;
        repeat (3) tick();
        chk_eq("rst_ack", 32'(ack), 32'd0);
        chk_eq("rst_valid", 32'(vld), 32'd0);
        chk_eq("rst_data", 32'(pdata), 32'd0);
        chk_eq("rst_in_frame", 32'(in_frame), 32'd0);
        chk_eq("rst_crc_err", 32'(crc_err), 32'd0);
        chk_eq("rst_drop", 32'(drop), 32'd0);
        rst = 1'b0;
        repeat (2) tick();

        // 1: incrementing payload, dense strobes, always ready
        a0 = ack_pulses; e0 = err_pulses;
        send_frame(pl_inc, -1, 16, 1'b1, 1'b0);
        chk_eq("s1_ack_rise", 32'(ack), 32'd1);
        chk_eq("s1_in_frame_low", 32'(in_frame), 32'd0);
        tick();
        chk_eq("s1_latency_valid", 32'(vld), 32'd1);
        wait_drain();
        chk_eq("s1_ack_pulses", 32'(ack_pulses - a0), 32'd1);
        chk_eq("s1_crc_errs", 32'(err_pulses - e0), 32'd0);

        // 2: one payload bit flipped, then a good frame
        a0 = ack_pulses; e0 = err_pulses;
        send_frame(pl_inc, 37, 16, 1'b0, 1'b0);
        chk_eq("s2_err_pulse", 32'(crc_err), 32'd1);
        chk_eq("s2_no_ack", 32'(ack), 32'd0);
        repeat (12) tick();
        chk_eq("s2_err_count", 32'(err_pulses - e0), 32'd1);
        chk_eq("s2_no_valid", 32'(vld), 32'd0);
        send_frame(pl_inc, -1, 16, 1'b1, 1'b0);
        chk_eq("s2_good_ack_rise", 32'(ack), 32'd1);
        wait_drain();
        chk_eq("s2_ack_pulses", 32'(ack_pulses - a0), 32'd1);

        // 3: 5 random bits of offset, sparse strobes, random payload
        a0 = ack_pulses; e0 = err_pulses;
        for (int i = 0; i < 5; i++) send_bit(1'($urandom_range(0, 1)), 1'b1);
        send_frame(pl_rnd, -1, 16, 1'b1, 1'b1);
        chk_eq("s3_ack_rise", 32'(ack), 32'd1);
        wait_drain();
        chk_eq("s3_ack_pulses", 32'(ack_pulses - a0), 32'd1);
        chk_eq("s3_crc_errs", 32'(err_pulses - e0), 32'd0);

        // 4: ready toggling every cycle
        a0 = ack_pulses;
        rdy_mode = 1;
        send_frame(pl_alt, -1, 16, 1'b1, 1'b0);
        wait_drain();
        rdy_mode = 0;
        repeat (2) tick();
        chk_eq("s4_ack_pulses", 32'(ack_pulses - a0), 32'd1);

        // 5: drain stalled while a second frame arrives
        a0 = ack_pulses; d0 = drop_pulses;
        rdy_mode = 2;
        send_frame(pl_inc, -1, 16, 1'b1, 1'b0);
        chk_eq("s5_ack_rise", 32'(ack), 32'd1);
        send_byte(8'hF6, 1'b0);
        send_byte(8'h28, 1'b0);
        chk_eq("s5_drop_at_fas", 32'(drop), 32'd1);
        for (int k = 0; k < 16; k++) send_byte(pl_zero[k], 1'b0);
        send_byte(crc8_ref(pl_zero), 1'b0);
        chk_eq("s5_stalled", 32'(sb_q.size()), 32'd16);
        rdy_mode = 0;
        wait_drain();
        chk_eq("s5_ack_pulses", 32'(ack_pulses - a0), 32'd1);
        chk_eq("s5_drop_pulses", 32'(drop_pulses - d0), 32'd1);
`ifdef RX_STATS_EN
        chk_eq("stats_good", 32'(good_cnt), 32'd5);
        chk_eq("stats_bad", 32'(bad_cnt), 32'd1);
        chk_eq("stats_drop", 32'(drop_cnt), 32'd1);
`endif

        // 6: reset in the middle of payload byte 7, then a normal frame
        send_frame(pl_inc, -1, 7, 1'b0, 1'b0);
        chk_eq("s6_in_frame", 32'(in_frame), 32'd1);
        rst = 1'b1;
        tick();
        chk_eq("s6_rst_ack", 32'(ack), 32'd0);
        chk_eq("s6_rst_valid", 32'(vld), 32'd0);
        chk_eq("s6_rst_data", 32'(pdata), 32'd0);
        chk_eq("s6_rst_in_frame", 32'(in_frame), 32'd0);
        chk_eq("s6_rst_crc_err", 32'(crc_err), 32'd0);
        chk_eq("s6_rst_drop", 32'(drop), 32'd0);
`ifdef RX_STATS_EN
        chk_eq("s6_rst_good_cnt", 32'(good_cnt), 32'd0);
`endif
        rst = 1'b0;
        repeat (2) tick();
        a0 = ack_pulses;
        send_frame(pl_alt, -1, 16, 1'b1, 1'b0);
        chk_eq("s6_ack_rise", 32'(ack), 32'd1);
        wait_drain();
        chk_eq("s6_ack_pulses", 32'(ack_pulses - a0), 32'd1);
`ifdef RX_STATS_EN
        chk_eq("s6_stats_good", 32'(good_cnt), 32'd1);
        chk_eq("s6_stats_bad", 32'(bad_cnt), 32'd0);
        chk_eq("s6_stats_drop", 32'(drop_cnt), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
